// File: rtl/arb_mux_nto1_pkg.sv
// -----------------------------------------------------------------------------
// arb_mux_nto1_pkg
// Shared definitions for the N:1 arbitrated output-register multiplexer:
//   - default WIDTH / N constants
//   - clog2_min1() helper used to derive the channel-index width SELW
//   - output-register state encoding
// Optional build macro (consumed by rr_arbiter): ARB_MUX_FIXED_PRIO_EN
// -----------------------------------------------------------------------------
package arb_mux_nto1_pkg;

  localparam int unsigned ARB_MUX_DEF_WIDTH = 32'd32;
  localparam int unsigned ARB_MUX_DEF_N     = 32'd4;

  // Index width for n channels; never narrower than one bit so N=1 still
  // gets a legal out_sel port.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 32'd0;
    while ((32'd1 << w) < n) begin
      w = w + 32'd1;
    end
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

  // The output register is the only state: empty or holding a word.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/arb_mux_nto1_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational N-way arbiter. Grants the first requesting channel found when
// searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N, N need not be a
// power of two). The pointer register lives in the parent.
// Build option ARB_MUX_FIXED_PRIO_EN: the search always starts at index 0
// (lowest index wins) and ptr is ignored.
// Ports:
//   req     [N]     request vector
//   ptr     [SELW]  search start index (must be < N)
//   gnt     [N]     one-hot grant
//   gnt_idx [SELW]  index of the granted channel (0 when none)
//   any_gnt         at least one request was granted
// -----------------------------------------------------------------------------
module rr_arbiter
  import arb_mux_nto1_pkg::*;
#(
  parameter int unsigned N    = ARB_MUX_DEF_N,
  parameter int unsigned SELW = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any_gnt
);

  int unsigned start_s;

`ifdef ARB_MUX_FIXED_PRIO_EN
  logic unused_ptr_s;
  assign unused_ptr_s = ^ptr;
  assign start_s      = 32'd0;
`else
  assign start_s      = 32'(ptr);
`endif

  // Rotating first-one search; ptr < N so one conditional subtract wraps.
  always_comb begin
    int unsigned idx;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 32'd0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = start_s + k;
      if (idx >= N) begin
        idx = idx - N;
      end else begin
        idx = idx;
      end
      if (!any_gnt && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = SELW'(idx);
        any_gnt  = 1'b1;
      end else begin
        any_gnt  = any_gnt;
      end
    end
  end

endmodule

// File: rtl/arb_mux_nto1.sv
// -----------------------------------------------------------------------------
// arb_mux_nto1
// N-input, WIDTH-bit registered multiplexer with round-robin arbitration and
// valid/ready handshakes. One cycle latency, one word per cycle throughput.
// Build option ARB_MUX_FIXED_PRIO_EN: fixed priority (index 0 highest),
// selected inside rr_arbiter; ports and latency are unchanged.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid  [N]       per-channel request
//   in_data   [N*WIDTH] channel i at [i*WIDTH +: WIDTH]
//   in_ready  [N]       per-channel accept (at most one bit high)
//   out_valid           output register holds a word
//   out_data  [WIDTH]   registered word of the granted channel
//   out_sel   [SELW]    index of the channel that produced out_data
//   out_ready           consumer takes out_data this cycle
// Note: in_ready depends combinationally on out_ready.
// -----------------------------------------------------------------------------
module arb_mux_nto1
  import arb_mux_nto1_pkg::*;
#(
  parameter  int unsigned WIDTH = ARB_MUX_DEF_WIDTH,
  parameter  int unsigned N     = ARB_MUX_DEF_N,
  localparam int unsigned SELW  = clog2_min1(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  out_state_e        state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [SELW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [N-1:0]      gnt_s;
  logic [SELW-1:0]   gnt_idx_s;
  logic              any_gnt_s;
  logic              accept_s;
  logic              load_s;
  logic [WIDTH-1:0]  sel_data_s;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .any_gnt (any_gnt_s)
  );

  // Register can take a word when empty or when its current word drains now.
  assign accept_s  = (state_q == ST_EMPTY) | out_ready;
  assign load_s    = any_gnt_s & accept_s & ~reset;
  // gnt is a subset of in_valid, so in_ready never rises for an idle channel.
  assign in_ready  = reset ? '0 : (gnt_s & {N{accept_s}});

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

  // AND-OR data select over the one-hot grant; no priority chain on data.
  always_comb begin
    sel_data_s = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sel_data_s = sel_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt_s[i]}});
    end
  end

  // Next-state: load on transfer, drain to empty when consumed, else hold.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    if (load_s) begin
      state_d  = ST_FULL;
      data_d   = sel_data_s;
      sel_d    = gnt_idx_s;
      rr_ptr_d = (gnt_idx_s == SELW'(N - 32'd1)) ? '0 : (gnt_idx_s + SELW'(1'b1));
    end else if (out_ready) begin
      state_d  = ST_EMPTY;
    end else begin
      state_d  = state_q;
    end
  end

  // Output register, handshake state and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      data_q   <= '0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_arb_mux_nto1.sv
// -----------------------------------------------------------------------------
// tb_arb_mux_nto1
// Directed bench for arb_mux_nto1 with N=4, WIDTH=32. Inputs change 1 time
// unit after a rising edge; in_ready is checked before the next edge and the
// registered outputs 1 time unit after it.
// -----------------------------------------------------------------------------
module tb_arb_mux_nto1;

  localparam int unsigned W  = 32;
  localparam int unsigned NC = 4;

  logic            clk;
  logic            reset;
  logic [NC-1:0]   in_valid;
  logic [NC*W-1:0] in_data;
  logic [NC-1:0]   in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [1:0]      out_sel;
  logic            out_ready;

  int n_cmp;
  int n_bad;

  arb_mux_nto1 #(.WIDTH(W), .N(NC)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] val);
    in_data[ch*W +: W] = val;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [31:0] d);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".sel"},   32'(out_sel),   32'(s));
    chk({tag, ".data"},  out_data,       d);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in_data   = '0;
    for (int i = 0; i < 4; i++) set_ch(i, 32'hA0 + 32'(i));

    // Reset held for two cycles with every channel requesting.
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data",  out_data,       32'd0);
      chk("rst_sel",   32'(out_sel),   32'd0);
      chk("rst_ready", 32'(in_ready),  32'd0);
    end
    reset = 1'b0;

`ifdef ARB_MUX_FIXED_PRIO_EN
    // Fixed priority: ch0 and ch2 both request, ch0 always wins.
    in_valid = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("fp_ready", 32'(in_ready), 32'h1);
      tick();
      chk_out("fp_out", 1'b1, 2'd0, 32'hA0);
    end
`else
    // Round-robin with all channels requesting: 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_ready", 32'(in_ready), 32'd1 << (i % 4));
      tick();
      chk_out("rr_out", 1'b1, 2'(i % 4), 32'hA0 + 32'(i % 4));
    end
    // Pointer now at 1. Only ch3 requests.
    in_valid = 4'b1000;
    set_ch(3, 32'h33);
    #1;
    chk("sp3_ready", 32'(in_ready), 32'h8);
    tick();
    chk_out("sp3_out", 1'b1, 2'd3, 32'h33);
    // Pointer wrapped to 0: ch1 beats ch3.
    in_valid = 4'b1010;
    set_ch(1, 32'h11);
    #1;
    chk("sp13_ready", 32'(in_ready), 32'h2);
    tick();
    chk_out("sp1_out", 1'b1, 2'd1, 32'h11);
    in_valid = 4'b1000;
    #1;
    chk("sp3b_ready", 32'(in_ready), 32'h8);
    tick();
    chk_out("sp3b_out", 1'b1, 2'd3, 32'h33);

    // Backpressure: load DEADBEEF from ch0, then stall with ch2 waiting.
    in_valid = 4'b0001;
    set_ch(0, 32'hDEADBEEF);
    #1;
    chk("bp_load_ready", 32'(in_ready), 32'h1);
    tick();
    chk_out("bp_load", 1'b1, 2'd0, 32'hDEADBEEF);
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    set_ch(2, 32'hC2C2C2C2);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_stall_ready", 32'(in_ready), 32'h0);
      tick();
      chk_out("bp_stall", 1'b1, 2'd0, 32'hDEADBEEF);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h4);
    tick();
    chk_out("bp_release", 1'b1, 2'd2, 32'hC2C2C2C2);

    // Reset pulse while FULL with out_sel=2; pointer would otherwise be 3.
    reset    = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_ch(i, 32'hA0 + 32'(i));
    #1;
    chk("mid_rst_ready", 32'(in_ready), 32'h0);
    tick();
    chk_out("mid_rst", 1'b0, 2'd0, 32'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'h1);
    tick();
    chk_out("post_rst", 1'b1, 2'd0, 32'hA0);

    // No requests: drain to empty, data/sel hold.
    in_valid = 4'b0000;
    #1;
    chk("drain_ready", 32'(in_ready), 32'h0);
    tick();
    chk_out("drain", 1'b0, 2'd0, 32'hA0);

    // Empty register accepts even with out_ready low; pointer is at 1.
    out_ready = 1'b0;
    in_valid  = 4'b0110;
    set_ch(1, 32'h11);
    #1;
    chk("empty_acc_ready", 32'(in_ready), 32'h2);
    tick();
    chk_out("empty_acc", 1'b1, 2'd1, 32'h11);
    in_valid = 4'b0100;
    #1;
    chk("full_hold_ready", 32'(in_ready), 32'h0);
    tick();
    chk_out("full_hold", 1'b1, 2'd1, 32'h11);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
